// File: rtl/branch_predictor_pht_pkg.sv
// Shared definitions for the PHT branch predictor: 2-bit counter states,
// branch opcode and the saturating counter transition function.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Weakly-not-taken start lets a single taken outcome flip the prediction.
    localparam logic [1:0] PHT_RST_VAL = WNT;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        nxt = state;
        if (taken) begin
            if (state != ST) begin
                nxt = state + 2'd1;
            end
        end else begin
            if (state != SNT) begin
                nxt = state - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_pht_stat.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Registered, one-cycle update latency; no backpressure.
module bp_sat_stat_counter #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    output logic [STAT_W-1:0] count_o
);

    logic [STAT_W-1:0] cnt_q;
    logic [STAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {STAT_W{1'b1}})) begin
            cnt_d = cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/branch_predictor_pht.sv
// Pattern history table of 2-bit counters with optional gshare indexing.
// Prediction and next-PC are combinational; table, history and stats update at the clock edge.
module branch_predictor_pht
    import bp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 6,
    parameter int GHR_W  = 6,
    parameter int MODE   = 0,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       inst,
    output logic              predict,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [XLEN-1:0]   next_pc,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       pht_q [DEPTH];
    logic [1:0]       pht_d [DEPTH];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    logic             is_b;
    logic [IDX_W-1:0] pc_idx;
    logic [12:0]      imm13;
    logic [XLEN-1:0]  imm_b;
    logic             unused_inst_bits;

    assign is_b   = (inst[6:2] == OPC_BRANCH);
    assign pc_idx = pc[IDX_W+1:2];

    generate
        if (MODE == 1) begin : g_gshare
            assign pred_idx = pc_idx ^ IDX_W'(ghr_q);
        end else begin : g_bimodal
            assign pred_idx = pc_idx;
        end
    endgenerate

    assign imm13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_b = {{(XLEN-13){imm13[12]}}, imm13};

    // Reads the registered table: an update this cycle is only seen next cycle.
    assign predict = is_b & pht_q[pred_idx][1];
    assign next_pc = predict ? (pc + imm_b) : (pc + XLEN'(4));

    assign unused_inst_bits = ^{inst[24:12], inst[1:0]};

    always_comb begin
        pht_d = pht_q;
        if (upd_valid) begin
            pht_d[upd_idx] = sat_update(pht_q[upd_idx], upd_taken);
        end
    end

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_d = upd_valid ? upd_taken : ghr_q;
        end else begin : g_ghr_shift
            assign ghr_d = upd_valid ? {ghr_q[GHR_W-2:0], upd_taken} : ghr_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= PHT_RST_VAL;
            end
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end

    bp_sat_stat_counter #(.STAT_W(STAT_W)) u_stat_br (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (upd_valid),
        .count_o (stat_branches)
    );

    bp_sat_stat_counter #(.STAT_W(STAT_W)) u_stat_mis (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (upd_valid & upd_mispredict),
        .count_o (stat_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Bench: bimodal (IDX 6, STAT 32) and gshare (IDX/GHR 4, STAT 4) instances share stimulus.
module tb_branch_predictor_pht;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        p0, p1;
    logic [5:0]  pidx0;
    logic [3:0]  pidx1;
    logic [31:0] npc0, npc1;
    logic [31:0] sb0, sm0;
    logic [3:0]  sb1, sm1;

    branch_predictor_pht #(.XLEN(32), .IDX_W(6), .GHR_W(6), .MODE(0), .STAT_W(32)) dut0 (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst),
        .predict(p0), .pred_idx(pidx0), .next_pc(npc0),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict),
        .stat_branches(sb0), .stat_mispredicts(sm0)
    );

    branch_predictor_pht #(.XLEN(32), .IDX_W(4), .GHR_W(4), .MODE(1), .STAT_W(4)) dut1 (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst),
        .predict(p1), .pred_idx(pidx1), .next_pc(npc1),
        .upd_valid(upd_valid), .upd_idx(upd_idx[3:0]), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict),
        .stat_branches(sb1), .stat_mispredicts(sm1)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: counters as 0..3 integers, history as an integer modulo 2**W.
    int     m0_ctr [64];
    int     m1_ctr [16];
    int     m0_hist, m1_hist;
    longint m0_br, m0_mis, m1_br, m1_mis;

    function automatic int step_ctr(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    always @(posedge clk) begin : model
        int i0, i1;
        if (rst === 1'b0) begin
            for (int i = 0; i < 64; i++) m0_ctr[i] = 1;
            for (int i = 0; i < 16; i++) m1_ctr[i] = 1;
            m0_hist = 0; m1_hist = 0;
            m0_br = 0; m0_mis = 0; m1_br = 0; m1_mis = 0;
        end else if (upd_valid === 1'b1) begin
            i0 = int'(upd_idx);
            i1 = int'(upd_idx) % 16;
            m0_ctr[i0] = step_ctr(m0_ctr[i0], upd_taken);
            m1_ctr[i1] = step_ctr(m1_ctr[i1], upd_taken);
            m0_hist = (m0_hist * 2 + int'(upd_taken)) % 64;
            m1_hist = (m1_hist * 2 + int'(upd_taken)) % 16;
            if (m0_br < 64'hFFFF_FFFF) m0_br = m0_br + 1;
            if (m1_br < 15) m1_br = m1_br + 1;
            if (upd_mispredict) begin
                if (m0_mis < 64'hFFFF_FFFF) m0_mis = m0_mis + 1;
                if (m1_mis < 15) m1_mis = m1_mis + 1;
            end
        end
    end

    function automatic bit is_branch(input logic [31:0] ins);
        return ins[6:2] == 5'b11000;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] p, input logic [31:0] ins, input bit tk);
        int off;
        if (!tk) return p + 32'd4;
        off = 0;
        if (ins[31]) off -= 4096;
        if (ins[7])  off += 2048;
        off += int'(ins[30:25]) * 32;
        off += int'(ins[11:8]) * 2;
        return p + 32'(off);
    endfunction

    always @(negedge clk) begin : compare
        int  idx0, idx1;
        bit  e0, e1;
        if (chk_en) begin
            idx0 = int'((pc >> 2) % 64);
            idx1 = int'((pc >> 2) % 16) ^ m1_hist;
            e0 = is_branch(inst) && (m0_ctr[idx0] >= 2);
            e1 = is_branch(inst) && (m1_ctr[idx1] >= 2);
            chk("m_pidx0", pidx0, idx0);
            chk("m_pidx1", pidx1, idx1);
            chk("m_pred0", p0, e0);
            chk("m_pred1", p1, e1);
            chk("m_npc0", npc0, target(pc, inst, e0));
            chk("m_npc1", npc1, target(pc, inst, e1));
            chk("m_sb0", sb0, m0_br);
            chk("m_sm0", sm0, m0_mis);
            chk("m_sb1", sb1, m1_br);
            chk("m_sm1", sm1, m1_mis);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;  // beq, immB = +16
    localparam logic [31:0] BR_M8   = 32'hFE00_0CE3;  // branch, immB = -8
    localparam logic [31:0] ADDI    = 32'h0000_0013;

    initial begin
        logic [31:0] r;
        bit seq [4];
        rst = 1'b0; pc = '0; inst = ADDI;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset-state fetch
        pc = 32'h100; inst = BEQ_P16; #2;
        chk("rst_pred", p0, 0);
        chk("rst_npc", npc0, 32'h104);
        chk("rst_stat", sb0, 0);
        inst = ADDI; #2;
        chk("nb_pred", p0, 0);
        chk("nb_npc", npc0, 32'h104);

        // Train idx 0 (pc 0x100) up to ST
        upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1;
        tick(); tick();
        upd_valid = 1'b0; inst = BEQ_P16; #2;
        chk("train_pred", p0, 1);
        chk("train_npc", npc0, 32'h110);

        // ST -> WT -> WNT -> SNT, then SNT holds
        upd_valid = 1'b1; upd_taken = 1'b0;
        repeat (3) tick();
        upd_valid = 1'b0; #2;
        chk("untrain_pred", p0, 0);
        upd_valid = 1'b1; tick();
        upd_taken = 1'b1; tick();
        upd_valid = 1'b0; #2;
        chk("snt_hold_pred", p0, 0);

        // Negative offset and wrap-around
        upd_valid = 1'b1; upd_taken = 1'b1;
        repeat (2) tick();
        upd_valid = 1'b0;
        pc = 32'h0; inst = BR_M8; #2;
        chk("neg_pred", p0, 1);
        chk("neg_npc", npc0, 32'hFFFF_FFF8);
        pc = 32'hFFFF_FFFC; #2;
        chk("wrap_pred", p0, 0);
        chk("wrap_npc", npc0, 32'h0);

        // Gshare history T,T,N,T
        rst = 1'b0; tick(); rst = 1'b1;
        seq = '{1'b1, 1'b1, 1'b0, 1'b1};
        upd_valid = 1'b1; upd_idx = 6'd5;
        for (int i = 0; i < 4; i++) begin
            upd_taken = seq[i];
            tick();
        end
        upd_valid = 1'b0;
        pc = 32'h40; inst = ADDI; #2;
        chk("gs_idx", pidx1, 4'hD);
        chk("bm_idx", pidx0, 6'h10);
        rst = 1'b0; tick(); rst = 1'b1; #2;
        chk("gs_idx_rst", pidx1, 4'h0);

        // Same-cycle read/update: prediction uses pre-update value
        pc = 32'h100; inst = BEQ_P16;
        upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1;
        tick();
        upd_taken = 1'b0; #2;
        chk("same_pre", p0, 1);
        tick();
        upd_valid = 1'b0; #2;
        chk("same_post", p0, 0);

        // Reset dominates a coincident update
        upd_valid = 1'b1; upd_taken = 1'b1; tick();
        rst = 1'b0; tick();
        rst = 1'b1; upd_valid = 1'b0; #2;
        chk("rstupd_pred", p0, 0);
        chk("rstupd_npc", npc0, 32'h104);
        chk("rstupd_sb", sb0, 0);

        // Statistics saturation
        rst = 1'b0; tick(); rst = 1'b1;
        upd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            upd_mispredict = (i < 7);
            upd_idx = 6'($urandom);
            upd_taken = 1'($urandom);
            tick();
        end
        upd_valid = 1'b0; upd_mispredict = 1'b0; #2;
        chk("stat_br4", sb1, 15);
        chk("stat_mis4", sm1, 7);
        chk("stat_br32", sb0, 20);
        chk("stat_mis32", sm0, 7);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = r | 32'hFFFF_FF00;
            pc = r;
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[6:2] = 5'b11000;
            inst = r;
            upd_valid = ($urandom_range(0, 9) < 6);
            upd_idx = 6'($urandom);
            upd_taken = 1'($urandom);
            upd_mispredict = 1'($urandom);
            tick();
        end
        rst = 1'b1; upd_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_predictor_pht.md
Name: branch_predictor_pht

Overview:
- Parametrised successor to the single-counter branch predictor: a pattern history table (PHT) of 2-bit saturating counters, indexed by PC.
- Optional gshare mode XORs a global history register (GHR) into the index.
- Combinational prediction and next-PC generation in IF; registered table/GHR/statistics update from EX branch resolution.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_W, 6, PHT index width; table depth = 2**IDX_W.
- GHR_W, 6, global history width; legal range 1..IDX_W.
- MODE, 0, 0 = bimodal (index = PC bits only), 1 = gshare.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-low (rst==0 at posedge resets).
- pc  in  XLEN  IF-stage PC.
- inst  in  32  IF-stage instruction.
- predict  out  1  1 = predicted taken; 0 for non-branch instructions.
- pred_idx  out  IDX_W  PHT index used for this prediction; carried down the pipe.
- next_pc  out  XLEN  predicted fetch address.
- upd_valid  in  1  EX has resolved a conditional branch this cycle.
- upd_idx  in  IDX_W  pred_idx that travelled with the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  EX-computed: prediction differed from outcome.
- stat_branches  out  STAT_W  resolved branch count.
- stat_mispredicts  out  STAT_W  misprediction count.

Behaviour:
- Counter encoding (package): SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11. The MSB is the prediction.
- Reset (rst==0 at posedge): every PHT entry = WNT, GHR = 0, both stat counters = 0. Reset dominates upd_valid.
- After reset, predict = 0 for all PCs. next_pc = pc+4.
- Branch detection: is_b = (inst[6:2]==5'b11000).
- Index:
  - pc[IDX_W+1:2], XOR {zero-extended GHR} when MODE==1.
  - pred_idx always drives the computed index, even for non-branches.
- predict = is_b & PHT[pred_idx][1]. Combinational, 0-cycle latency.
- immB = sign-extend {inst[31],inst[7],inst[30:25],inst[11:8],1'b0} to XLEN.
- next_pc:
  - pc+immB if predict, else pc+4.
  - Addition is modulo 2**XLEN; wrap-around is silent.
- Update, at posedge with rst==1 and upd_valid==1:
  - PHT[upd_idx]: saturating increment if upd_taken, else saturating decrement. ST stays ST on taken; SNT stays SNT on not-taken.
  - Transitions are exactly: SNT->WNT->WT->ST (taken) and ST->WT->WNT->SNT (not taken).
  - GHR <= {GHR[GHR_W-2:0], upd_taken}. For GHR_W==1, GHR <= upd_taken.
  - The GHR also updates in MODE 0 but does not affect the index.
  - stat_branches += 1.
  - stat_mispredicts += upd_mispredict.
  - Both stat counters saturate at all-ones; no wrap.
- upd_valid==0: PHT, GHR and stats hold.
- Same-cycle read/write to the same index: the prediction uses the pre-update value; no bypass. The new value is visible the next cycle.
- Reset mid-operation: the in-flight upd_valid is discarded. Outputs reflect reset state in the cycle after the reset edge.
- Only one update port; at most one update per cycle.
- Inputs are assumed clean. X on upd_idx with upd_valid==1 is a bench error.

Decomposition:
- Package bp_pkg:
  - counter state localparams SNT/WNT/WT/ST and the reset value WNT;
  - OPC_BRANCH = 5'b11000;
  - function sat_update(state, taken) returning the next 2-bit state.
- One natural sub-module: bp_sat_stat_counter (STAT_W-wide saturating counter with sync active-low reset and increment enable), instantiated twice.
- PHT storage is an array of 2-bit registers inside the top; no RAM macro.

Test Plan:
- Reset then fetch: inst=beq (opcode 1100011) with immB=+16, pc=0x100 -> predict=0, next_pc=0x104. Non-branch inst -> predict=0, next_pc=pc+4.
- Counter training, MODE=0: two upd_valid taken updates at idx of pc=0x100 -> entry walks WNT->WT->ST; that branch then predicts 1, next_pc=0x110. Three not-taken updates -> ST->WT->WNT->SNT, predict=0. A fourth not-taken update keeps SNT.
- Negative offset and wrap: pc=0x0, immB=-8, entry at ST -> next_pc=0xFFFFFFF8. pc=0xFFFFFFFC, not-taken -> next_pc=0x0.
- Gshare aliasing, MODE=1, IDX_W=GHR_W=4: outcomes T,T,N,T give GHR=4'b1101. pc=0x40 (PC bits=0) -> pred_idx=4'hD. Same pc with GHR=0 -> pred_idx=0.
- Same-cycle read/update on the same index, entry at WT, upd not-taken -> predict=1 in that cycle, 0 in the next. Update with rst=0 in the same cycle -> entry=WNT, stats=0.
- Statistics with STAT_W=4: 20 updates, 7 with upd_mispredict=1 -> stat_branches=15 (saturated), stat_mispredicts=7.
